// File: rtl/exec_shift_issue_pkg.sv
// Shared widths, op encodings and stage payload types for the exec-stage shift issue block.
// Port summary: none (package only).
// Payload structs are packed so they pass straight through the generic register slice.
package exec_shift_issue_pkg;

  localparam int W_OPR   = 32;
  localparam int W_SHAMT = 5;
  localparam int W_TAG   = 5;

  // Keeps only the low W_SHAMT bits of a shift amount (modulo-W_OPR wrap).
  localparam logic [W_OPR-1:0] SHAMT_MASK = W_OPR'((1 << W_SHAMT) - 1);

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_SAR = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  // Stage 1: the op as received from decode.
  typedef struct packed {
    op_e              op;
    logic [W_OPR-1:0] opr0;
    logic [W_OPR-1:0] opr1;
    logic [W_TAG-1:0] tag;
  } s1_t;

  // Stage 2: the captured shifter result ready for writeback.
  typedef struct packed {
    logic [W_OPR-1:0] result;
    logic [W_TAG-1:0] tag;
    logic             illegal;
  } s2_t;

endpackage

// File: rtl/exec_shift_pipe_reg.sv
// Generic valid/ready register slice with synchronous flush; W-bit payload.
// Latency 1 cycle; full throughput because in_ready looks through to out_ready.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module exec_shift_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load;

  // Ready whenever the slot is empty or is being drained this cycle.
  // Deliberately independent of flush so upstream sees a stable ready.
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      // Payload is left untouched by flush; only the valid bit matters.
      if (load) begin
        data_q <= in_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/exec_shift_issue.sv
// Issue/collect controller around the exec-stage combinational shifter: registers ops, drives the shifter, captures results.
// Latency: accepting cycle to out_valid_o is 2 cycles; 1 op/cycle sustained; up to 2 ops buffered under backpressure.
// Backpressure: in_ready_o drops only when both stages hold data and out_ready_i is low; flush_i drops everything in flight.
// Ports: decode side in_*; shifter side sh_opr0_o/sh_opr1_o/sh_shl_o/sh_ash_o and sh_result_i;
//        writeback side out_*; flush_i and busy_o for pipeline control.
// Optional macro EXEC_SHIFT_MASK_EN: when defined, the shift amount sent to the shifter wraps modulo W_OPR.
module exec_shift_issue
  import exec_shift_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [W_OPR-1:0] in_opr0_i,
  input  logic [W_OPR-1:0] in_opr1_i,
  input  logic [W_TAG-1:0] in_tag_i,
  output logic [W_OPR-1:0] sh_opr0_o,
  output logic [W_OPR-1:0] sh_opr1_o,
  output logic             sh_shl_o,
  output logic             sh_ash_o,
  input  logic [W_OPR-1:0] sh_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W_OPR-1:0] out_result_o,
  output logic [W_TAG-1:0] out_tag_o,
  output logic             out_illegal_o,
  output logic             busy_o
);

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic s1_valid;
  logic s2_free;

  assign s1_d = '{op: op_e'(in_op_i), opr0: in_opr0_i, opr1: in_opr1_i, tag: in_tag_i};

  exec_shift_pipe_reg #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_free),
    .out_data  (s1_q)
  );

  // Shifter drive comes from S1 only and is forced to zero while S1 is empty
  // so the shifter inputs do not toggle on stale data.
  always_comb begin
    sh_opr0_o = '0;
    sh_opr1_o = '0;
    sh_shl_o  = 1'b0;
    sh_ash_o  = 1'b0;
    if (s1_valid) begin
      sh_opr0_o = s1_q.opr0;
`ifdef EXEC_SHIFT_MASK_EN
      sh_opr1_o = s1_q.opr1 & SHAMT_MASK;
`else
      sh_opr1_o = s1_q.opr1;
`endif
      sh_shl_o  = (s1_q.op == OP_SHL);
      sh_ash_o  = (s1_q.op == OP_SAR);
    end
  end

  // Illegal ops still flow down the pipe so writeback sees the tag, but with a zero result.
  always_comb begin
    s2_d         = '0;
    s2_d.illegal = (s1_q.op == OP_ILL);
    s2_d.result  = s2_d.illegal ? '0 : sh_result_i;
    s2_d.tag     = s1_q.tag;
  end

  exec_shift_pipe_reg #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (s1_valid),
    .in_ready  (s2_free),
    .in_data   (s2_d),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (s2_q)
  );

  assign out_result_o  = s2_q.result;
  assign out_tag_o     = s2_q.tag;
  assign out_illegal_o = s2_q.illegal;
  assign busy_o        = s1_valid || out_valid_o;

endmodule

// File: tb/tb_exec_shift_issue.sv
// Self-checking bench for exec_shift_issue: a local shifter drives sh_result_i, a scoreboard
// built from the shift rules predicts every writeback, plus a table of fixed vectors and
// hand-written sequences for back-to-back, backpressure, flush and mid-stream reset.
module tb_exec_shift_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  in_op_i;
  logic [31:0] in_opr0_i;
  logic [31:0] in_opr1_i;
  logic [4:0]  in_tag_i;
  logic [31:0] sh_opr0_o;
  logic [31:0] sh_opr1_o;
  logic        sh_shl_o;
  logic        sh_ash_o;
  logic [31:0] sh_result_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [4:0]  out_tag_o;
  logic        out_illegal_o;
  logic        busy_o;

  always #5 clk = ~clk;

  exec_shift_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_op_i      (in_op_i),
    .in_opr0_i    (in_opr0_i),
    .in_opr1_i    (in_opr1_i),
    .in_tag_i     (in_tag_i),
    .sh_opr0_o    (sh_opr0_o),
    .sh_opr1_o    (sh_opr1_o),
    .sh_shl_o     (sh_shl_o),
    .sh_ash_o     (sh_ash_o),
    .sh_result_i  (sh_result_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_tag_o    (out_tag_o),
    .out_illegal_o(out_illegal_o),
    .busy_o       (busy_o)
  );

  // Stand-in for the exec-level combinational shifter.
  logic signed [31:0] sar_v;
  assign sar_v = $signed(sh_opr0_o) >>> sh_opr1_o;
  always_comb begin
    if (sh_shl_o)      sh_result_i = sh_opr0_o << sh_opr1_o;
    else if (sh_ash_o) sh_result_i = sar_v;
    else               sh_result_i = sh_opr0_o >> sh_opr1_o;
  end

  int vectors    = 0;
  int miscompares = 0;
  int nout       = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp_res;
    logic        exp_ill;
  } vec_t;

  // Reference: apply the shift one bit position at a time, amount saturating at the width.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    int unsigned amt;
    r = a;
`ifdef EXEC_SHIFT_MASK_EN
    amt = b % 32;
`else
    amt = (b >= 32) ? 32 : b;
`endif
    if (op == 2'b11) return 32'h0;
    for (int i = 0; i < amt; i++) begin
      case (op)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        default: r = {r[31], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check handshake-side outputs against the model, advance the
  // scoreboard, then step to just after the next rising edge.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic ordy,
                       input logic fl);
    exp_t e;
    int   occ;
    in_valid_i  = v;
    in_op_i     = op;
    in_opr0_i   = a;
    in_opr1_i   = b;
    in_tag_i    = tag;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    occ = sbq.size();
    chk("in_ready", 32'(in_ready_o), 32'((occ < 2) || ordy));
    chk("busy", 32'(busy_o), 32'(occ > 0));
    if (out_valid_o && ordy) begin
      nout++;
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got result 0x%08h tag %0d, expected no output",
                 out_result_o, out_tag_o);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", out_result_o, e.res);
        chk("sb_tag", 32'(out_tag_o), 32'(e.tag));
        chk("sb_illegal", 32'(out_illegal_o), 32'(e.ill));
      end
    end
    if (v && in_ready_o && !fl) begin
      e.res = ref_shift(op, a, b);
      e.tag = tag;
      e.ill = (op == 2'b11);
      sbq.push_back(e);
    end
    if (fl) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{2'b00, 32'h0000_0001, 32'd4,  5'd3,  32'h0000_0010, 1'b0};
    vt[1] = '{2'b01, 32'h8000_0000, 32'd31, 5'd7,  32'h0000_0001, 1'b0};
    vt[2] = '{2'b10, 32'h8000_0000, 32'd31, 5'd9,  32'hFFFF_FFFF, 1'b0};
    vt[3] = '{2'b11, 32'hFFFF_FFFF, 32'd7,  5'd21, 32'h0000_0000, 1'b1};
`ifdef EXEC_SHIFT_MASK_EN
    vt[4] = '{2'b00, 32'h0000_0001, 32'd33, 5'd12, 32'h0000_0002, 1'b0};
    vt[5] = '{2'b10, 32'h8000_0000, 32'd40, 5'd13, 32'hFF80_0000, 1'b0};
`else
    vt[4] = '{2'b00, 32'h0000_0001, 32'd33, 5'd12, 32'h0000_0000, 1'b0};
    vt[5] = '{2'b10, 32'h8000_0000, 32'd40, 5'd13, 32'hFFFF_FFFF, 1'b0};
`endif
    vt[6] = '{2'b01, 32'h0000_00F0, 32'd0,  5'd31, 32'h0000_00F0, 1'b0};

    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_op_i = 2'b00;
    in_opr0_i = '0; in_opr1_i = '0; in_tag_i = '0; out_ready_i = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_result", out_result_o, 32'h0);
    chk("rst_tag", 32'(out_tag_o), 32'd0);
    chk("rst_illegal", 32'(out_illegal_o), 32'd0);
    chk("rst_sh", {sh_opr0_o[15:0] | sh_opr1_o[15:0], 14'd0, sh_shl_o, sh_ash_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Isolated ops: out_valid low one cycle after accept, high the cycle after.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].tag, 1'b1, 1'b0);
      chk("lat_out_valid_early", 32'(out_valid_o), 32'd0);
      idle(1'b1);
      chk("lat_out_valid", 32'(out_valid_o), 32'd1);
      chk("vec_result", out_result_o, vt[i].exp_res);
      chk("vec_tag", 32'(out_tag_o), 32'(vt[i].tag));
      chk("vec_illegal", 32'(out_illegal_o), 32'(vt[i].exp_ill));
      idle(1'b1);
    end

    // Back-to-back SAR then SHR.
    cycle(1'b1, 2'b10, 32'h8000_0000, 32'd4, 5'd1, 1'b1, 1'b0);
    cycle(1'b1, 2'b01, 32'h8000_0000, 32'd4, 5'd2, 1'b1, 1'b0);
    chk("b2b_first", out_result_o, 32'hF800_0000);
    idle(1'b1);
    chk("b2b_second_valid", 32'(out_valid_o), 32'd1);
    chk("b2b_second", out_result_o, 32'h0800_0000);
    idle(1'b1);

    // Backpressure: two accepted, third held off until release.
    nout = 0;
    cycle(1'b1, 2'b00, 32'h0000_0003, 32'd1, 5'd4, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'h0000_0003, 32'd2, 5'd5, 1'b0, 1'b0);
    chk("bp_in_ready_full", 32'(in_ready_o), 32'd0);
    cycle(1'b1, 2'b00, 32'h0000_0003, 32'd3, 5'd6, 1'b0, 1'b0);
    chk("bp_hold_result", out_result_o, 32'h0000_0006);
    chk("bp_hold_tag", 32'(out_tag_o), 32'd4);
    cycle(1'b1, 2'b00, 32'h0000_0003, 32'd3, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("bp_out_count", 32'(nout), 32'd3);
    chk("bp_drained", 32'(sbq.size()), 32'd0);

    // Flush with both stages full and an op offered in the same cycle.
    nout = 0;
    cycle(1'b1, 2'b00, 32'h1, 32'd1, 5'd10, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'h1, 32'd2, 5'd11, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 32'h1, 32'd3, 5'd12, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("flush_no_output", 32'(nout), 32'd0);

    // Asynchronous reset in the middle of a stream.
    cycle(1'b1, 2'b01, 32'hFFFF_0000, 32'd8, 5'd17, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 32'hFFFF_0000, 32'd4, 5'd18, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_result", out_result_o, 32'h0);
    chk("arst_sh_opr0", sh_opr0_o, 32'h0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1'b1);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 40));
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, b,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("rand_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
